dmem_responder: RTL and testbench

Data-memory responder for the CPU data bus. The core issues a request (address, write data, direction, byte/word size); this block serves it from a word-addressed RAM after a programmable number of wait states and returns read data with a one-cycle `ready` pulse. It supports word and byte (LDRB/STRB-style) accesses and flags out-of-range or misaligned accesses. It sits between the core's load/store path and on-chip data RAM, replacing the zero-latency memory model in multi-cycle builds.

---
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one word/byte load or store at a time from a
// word-addressed RAM after WAIT wait states, then pulses ready for one cycle.
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_sel,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q;
  logic [31:0]   wd_q;
  logic          we_q;
  logic          byte_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          req_err;
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [31:0]   merged;
  logic [7:0]    lane_byte;

  // Word index beyond the RAM, or a word access not on a 4-byte boundary.
  assign req_err = ({2'b00, a[31:2]} >= 32'(DEPTH)) ||
                   (!byte_sel && (a[1:0] != 2'b00));

  assign idx  = a_q[IW+1:2];
  assign lane = a_q[1:0];
  assign word = mem[idx];

  always_comb begin
    merged    = word;
    lane_byte = word[7:0];
    case (lane)
      2'd0: begin merged[7:0]   = wd_q[7:0]; lane_byte = word[7:0];   end
      2'd1: begin merged[15:8]  = wd_q[7:0]; lane_byte = word[15:8];  end
      2'd2: begin merged[23:16] = wd_q[7:0]; lane_byte = word[23:16]; end
      default: begin merged[31:24] = wd_q[7:0]; lane_byte = word[31:24]; end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign ready     = (state == S_RESP);
  assign err       = ready & err_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd     <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      byte_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            a_q    <= a;
            wd_q   <= wd;
            we_q   <= we;
            byte_q <= byte_sel;
            err_q  <= req_err;
            if (req_err) begin
              state <= S_RESP;
            end else if (WAIT > 0) begin
              state <= S_WAIT;
              cnt   <= CW'((WAIT > 0) ? WAIT - 1 : 0);
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_ACCESS;
          else           cnt   <= cnt - 1'b1;
        end
        S_ACCESS: begin
          if (!we_q) rd <= byte_q ? {24'b0, lane_byte} : word;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset on the ACCESS closing edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && (state == S_ACCESS) && we_q) begin
      mem[idx] <= byte_q ? merged : wd_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT=2 and one with WAIT=0,
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i [2];
  logic        req_i   [2];
  logic        we_i    [2];
  logic        bsel_i  [2];
  logic [31:0] a_i     [2];
  logic [31:0] wd_i    [2];
  logic [31:0] rd_o    [2];
  logic        ready_o [2];
  logic        err_o   [2];
  logic        busy_o  [2];
  logic [1:0]  st_o    [2];

  int n_chk  = 0;
  int n_fail = 0;
  int ecount = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: one outstanding request per instance, finishing
  // at a known edge; RAM kept as a plain array.
  logic [31:0] m_mem [2][64];
  logic [31:0] m_rd  [2];
  bit          m_act [2];
  int          m_done[2];
  bit          m_err [2];
  bit          m_we  [2];
  bit          m_b   [2];
  logic [31:0] m_a   [2];
  logic [31:0] m_wd  [2];
  int          lat_of[2] = '{3, 1};

  dmem_responder #(.DEPTH(64), .WAIT(2)) u_dut_w2 (
    .clk(clk), .reset(reset_i[0]), .req(req_i[0]), .we(we_i[0]),
    .byte_sel(bsel_i[0]), .a(a_i[0]), .wd(wd_i[0]), .rd(rd_o[0]),
    .ready(ready_o[0]), .err(err_o[0]), .busy(busy_o[0]), .dbg_state(st_o[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT(0)) u_dut_w0 (
    .clk(clk), .reset(reset_i[1]), .req(req_i[1]), .we(we_i[1]),
    .byte_sel(bsel_i[1]), .a(a_i[1]), .wd(wd_i[1]), .rd(rd_o[1]),
    .ready(ready_o[1]), .err(err_o[1]), .busy(busy_o[1]), .dbg_state(st_o[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [31:0] addr, input logic b);
    return ((addr / 4) >= 64) || (!b && ((addr % 4) != 0));
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] old, input logic [31:0] d,
                                           input logic [1:0] ln);
    logic [31:0] mask;
    mask = 32'hFF << {ln, 3'b000};
    return (old & ~mask) | ((d & 32'hFF) << {ln, 3'b000});
  endfunction

  always @(posedge clk) begin
    ecount <= ecount + 1;
    for (int u = 0; u < 2; u++) begin
      if (!reset_i[u]) begin
        m_act[u] <= 1'b0;
        m_rd[u]  <= '0;
      end else begin
        if (m_act[u] && (ecount + 1 == m_done[u] + 1)) m_act[u] <= 1'b0;
        if (m_act[u] && (ecount + 1 == m_done[u]) && !m_err[u]) begin
          if (m_we[u])
            m_mem[u][m_a[u][7:2]] <= m_b[u] ? put_byte(m_mem[u][m_a[u][7:2]], m_wd[u], m_a[u][1:0])
                                            : m_wd[u];
          else
            m_rd[u] <= m_b[u] ? ((m_mem[u][m_a[u][7:2]] >> {m_a[u][1:0], 3'b000}) & 32'hFF)
                              : m_mem[u][m_a[u][7:2]];
        end
        if (!m_act[u] && req_i[u]) begin
          m_act[u]  <= 1'b1;
          m_err[u]  <= is_err(a_i[u], bsel_i[u]);
          m_done[u] <= ecount + 1 + (is_err(a_i[u], bsel_i[u]) ? 0 : lat_of[u]);
          m_we[u]   <= we_i[u];
          m_b[u]    <= bsel_i[u];
          m_a[u]    <= a_i[u];
          m_wd[u]   <= wd_i[u];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk(u == 0 ? "w2_busy" : "w0_busy", 32'(busy_o[u]), 32'(m_act[u]));
        chk(u == 0 ? "w2_ready" : "w0_ready", 32'(ready_o[u]),
            32'(m_act[u] && (m_done[u] == ecount)));
        chk(u == 0 ? "w2_err" : "w0_err", 32'(err_o[u]),
            32'(m_act[u] && (m_done[u] == ecount) && m_err[u]));
        chk(u == 0 ? "w2_rd" : "w0_rd", rd_o[u], m_rd[u]);
      end
    end
  end

  task automatic do_req(input int u, input logic w, input logic b, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_lat,
                        output logic e, output logic [31:0] r);
    int lat;
    @(negedge clk);
    req_i[u] = 1'b1; we_i[u] = w; bsel_i[u] = b; a_i[u] = addr; wd_i[u] = data;
    @(negedge clk);
    req_i[u] = 1'b0;
    lat = 0;
    while (!ready_o[u] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    e = err_o[u];
    r = rd_o[u];
  endtask

  logic        e;
  logic [31:0] r;
  int          cnt;
  int          rdy_idx[$];
  int          idx;

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset_i[u] = 1'b0; req_i[u] = 1'b0; we_i[u] = 1'b0;
      bsel_i[u] = 1'b0; a_i[u] = '0; wd_i[u] = '0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_rd", rd_o[0], 32'h0);
    chk("reset_state", 32'(st_o[0]), 32'h0);
    @(negedge clk);
    reset_i[0] = 1'b1; reset_i[1] = 1'b1;

    // WAIT=2 word and byte traffic
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h12345678, 3, e, r);
    chk("st_err", 32'(e), 32'h0);
    do_req(0, 1'b0, 1'b0, 32'h40, 32'h0, 3, e, r);
    chk("ld_word", r, 32'h12345678);
    chk("ld_err", 32'(e), 32'h0);
    do_req(0, 1'b1, 1'b1, 32'h42, 32'h5A5A5AAB, 3, e, r);
    do_req(0, 1'b0, 1'b0, 32'h40, 32'h0, 3, e, r);
    chk("ld_merged", r, 32'h12AB5678);
    do_req(0, 1'b0, 1'b1, 32'h42, 32'h0, 3, e, r);
    chk("ldb_42", r, 32'h000000AB);
    do_req(0, 1'b0, 1'b1, 32'h43, 32'h0, 3, e, r);
    chk("ldb_43", r, 32'h00000012);

    // error cases complete immediately and leave rd alone
    do_req(0, 1'b0, 1'b0, 32'h41, 32'h0, 0, e, r);
    chk("misalign_err", 32'(e), 32'h1);
    chk("misalign_rd", r, 32'h00000012);
    do_req(0, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 0, e, r);
    chk("range_err", 32'(e), 32'h1);
    chk("range_rd", r, 32'h00000012);
    do_req(0, 1'b0, 1'b0, 32'h40, 32'h0, 3, e, r);
    chk("ram_kept", r, 32'h12AB5678);

    // reset during ACCESS aborts the store
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h5, 3, e, r);
    @(negedge clk);
    req_i[0] = 1'b1; we_i[0] = 1'b1; bsel_i[0] = 1'b0; a_i[0] = 32'h10; wd_i[0] = 32'hFFFFFFFF;
    @(negedge clk);
    req_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_i[0] = 1'b0;
    @(negedge clk);
    reset_i[0] = 1'b1;
    chk("abort_rd", rd_o[0], 32'h0);
    chk("abort_ready", 32'(ready_o[0]), 32'h0);
    chk("abort_busy", 32'(busy_o[0]), 32'h0);
    chk("abort_err", 32'(err_o[0]), 32'h0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 3, e, r);
    chk("abort_kept", r, 32'h00000005);

    // req pulses while busy are ignored
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h11, 3, e, r);
    @(negedge clk);
    req_i[0] = 1'b1; we_i[0] = 1'b1; a_i[0] = 32'h24; wd_i[0] = 32'h22;
    @(negedge clk);
    req_i[0] = 1'b0;
    @(negedge clk);
    req_i[0] = 1'b1; a_i[0] = 32'h20; wd_i[0] = 32'hDEAD;
    @(negedge clk);
    req_i[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready_o[0]) cnt++;
    end
    chk("busy_one_ready", 32'(cnt), 32'h1);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 3, e, r);
    chk("busy_ignored", r, 32'h11);
    do_req(0, 1'b0, 1'b0, 32'h24, 32'h0, 3, e, r);
    chk("busy_taken", r, 32'h22);

    // WAIT=0
    do_req(1, 1'b1, 1'b0, 32'h64, 32'h7, 1, e, r);
    do_req(1, 1'b0, 1'b0, 32'h64, 32'h0, 1, e, r);
    chk("w0_ld", r, 32'h7);
    @(negedge clk);
    req_i[1] = 1'b1; we_i[1] = 1'b0; bsel_i[1] = 1'b0; a_i[1] = 32'h64;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ready_o[1]) rdy_idx.push_back(i);
    end
    req_i[1] = 1'b0;
    chk("held_count", 32'(rdy_idx.size()), 32'd5);
    if (rdy_idx.size() > 0) chk("held_first", 32'(rdy_idx[0]), 32'd1);
    for (int i = 1; i < rdy_idx.size(); i++)
      chk("held_gap", 32'(rdy_idx[i] - rdy_idx[i-1]), 32'd3);
    repeat (3) @(negedge clk);

    // randomized traffic on both instances
    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < 64; w++)
        do_req(u, 1'b1, 1'b0, 32'(w * 4), $urandom, lat_of[u], e, r);
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        idx = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 80) : $urandom_range(0, 63);
        req_i[u]   = 1'($urandom_range(0, 1));
        we_i[u]    = 1'($urandom_range(0, 1));
        bsel_i[u]  = 1'($urandom_range(0, 1));
        a_i[u]     = 32'(idx * 4 + $urandom_range(0, 3));
        wd_i[u]    = $urandom;
        reset_i[u] = ($urandom_range(0, 49) != 0);
      end
      @(negedge clk);
      req_i[u] = 1'b0; reset_i[u] = 1'b1;
      repeat (6) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
